// File: rtl/fetch_r32i_pkg.sv
// fetch_r32i_pkg: shared constants and queue entry type for the r32i fetch unit
package fetch_r32i_pkg;
    localparam int DATA_W = 32;
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] ins;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_r32i.sv
// fetch_queue_r32i: FIFO of fetched {addr, ins} entries with push/pop/flush
module fetch_queue_r32i #(
    parameter int W          = 64,
    parameter int QueueDepth = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PW = $clog2(QueueDepth);
    localparam int CW = PW + 1;
    logic [W-1:0]  r_mem [QueueDepth];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(QueueDepth));
    assign o_head  = r_mem[r_rp];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + PW'(1);
            if (i_pop) r_rp <= r_rp + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    // Storage needs no reset: entries are only visible while occupied
    always_ff @(posedge clock) begin
        if (i_push && !i_flush) r_mem[r_wp] <= i_data;
    end
endmodule

// File: rtl/fetch_unit_r32i.sv
// fetch_unit_r32i: sequential instruction fetch with redirect and fetch queue
// Optional stall performance counter enabled by macro FETCH_PERF_CNT_EN
module fetch_unit_r32i
    import fetch_r32i_pkg::*;
#(
    parameter int               dataW      = DATA_W,
    parameter int               QueueDepth = 4,
    parameter logic [dataW-1:0] ResetPC    = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             InsCacheStall,
    input  logic [dataW-1:0] OutputIns,
    output logic [dataW-1:0] ProgAddr,
    input  logic             BranchTaken,
    input  logic [dataW-1:0] BranchTarget,
    input  logic             DecodeReady,
    output logic             InsValid,
    output logic [dataW-1:0] InsOut,
    output logic [dataW-1:0] InsPC,
    output logic [31:0]      StallCount
);
    logic [2*dataW-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic [dataW-1:0]   r_pc;
    assign w_pop    = !w_empty && DecodeReady && !BranchTaken;
    assign w_push   = !InsCacheStall && !BranchTaken && (!w_full || w_pop);
    assign ProgAddr = r_pc;
    assign InsValid = !w_empty;
    assign InsOut   = w_empty ? '0 : w_head[dataW-1:0];
    assign InsPC    = w_empty ? '0 : w_head[2*dataW-1:dataW];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_pc <= ResetPC;
        else if (BranchTaken) r_pc <= BranchTarget;
        else if (w_push) r_pc <= r_pc + dataW'(1);
    end
    fetch_queue_r32i #(.W(2*dataW), .QueueDepth(QueueDepth)) u_queue (
        .clock   (clock),
        .reset   (reset),
        .i_flush (BranchTaken),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_pc, OutputIns}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_stall_cnt <= '0;
        else if (InsCacheStall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
    assign StallCount = r_stall_cnt;
`else
    assign StallCount = '0;
`endif
endmodule

// File: tb/tb_fetch_unit_r32i.sv
// tb_fetch_unit_r32i: directed checks of fetch_unit_r32i with a ProgAddr+100 cache model
module tb_fetch_unit_r32i;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        InsCacheStall = 1'b0;
    logic [31:0] OutputIns;
    logic [31:0] ProgAddr;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        DecodeReady = 1'b0;
    logic        InsValid;
    logic [31:0] InsOut;
    logic [31:0] InsPC;
    logic [31:0] StallCount;
    int total = 0;
    int bad = 0;
    always #5 clock = ~clock;
    assign OutputIns = ProgAddr + 32'd100;
    fetch_unit_r32i dut (
        .clock         (clock),
        .reset         (reset),
        .InsCacheStall (InsCacheStall),
        .OutputIns     (OutputIns),
        .ProgAddr      (ProgAddr),
        .BranchTaken   (BranchTaken),
        .BranchTarget  (BranchTarget),
        .DecodeReady   (DecodeReady),
        .InsValid      (InsValid),
        .InsOut        (InsOut),
        .InsPC         (InsPC),
        .StallCount    (StallCount)
    );
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        InsCacheStall = 1'b0;
        BranchTaken = 1'b0;
        DecodeReady = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        total++; if (ProgAddr !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", ProgAddr); end
        total++; if (InsValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", InsValid); end
        total++; if (InsOut !== 32'd0 || InsPC !== 32'd0) begin bad++; $display("FAIL reset_out got=%h/%h exp=0/0", InsOut, InsPC); end
        total++; if (StallCount !== 32'd0) begin bad++; $display("FAIL reset_stallcnt got=%0d exp=0", StallCount); end
        reset = 1'b0;
        step();
        total++; if (ProgAddr !== 32'd1) begin bad++; $display("FAIL first_fetch got=%h exp=1", ProgAddr); end
    endtask
    task automatic test_stream();
        do_reset();
        DecodeReady = 1'b1;
        total++; if (InsValid !== 1'b0) begin bad++; $display("FAIL stream_cycle0_valid got=%b exp=0", InsValid); end
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (InsValid !== 1'b1 || InsPC !== 32'(i) || InsOut !== 32'(100 + i)) begin
                bad++; $display("FAIL stream_%0d got=%b/%h/%0d exp=1/%h/%0d", i, InsValid, InsPC, InsOut, i, 100 + i);
            end
        end
    endtask
    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        total++; if (ProgAddr !== 32'd4) begin bad++; $display("FAIL full_hold_pc got=%h exp=4", ProgAddr); end
        DecodeReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (InsValid !== 1'b1 || InsPC !== 32'(i) || InsOut !== 32'(100 + i)) begin
                bad++; $display("FAIL drain_%0d got=%b/%h/%0d exp=1/%h/%0d", i, InsValid, InsPC, InsOut, i, 100 + i);
            end
            step();
        end
    endtask
    task automatic test_stall();
        do_reset();
        DecodeReady = 1'b1;
        for (int i = 0; i < 8; i++) step();
        total++; if (ProgAddr !== 32'd8) begin bad++; $display("FAIL pre_stall_pc got=%h exp=8", ProgAddr); end
        InsCacheStall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total++; if (ProgAddr !== 32'd8) begin bad++; $display("FAIL stall_hold_%0d got=%h exp=8", i, ProgAddr); end
        end
        total++; if (InsValid !== 1'b0) begin bad++; $display("FAIL stall_nopush got=%b exp=0", InsValid); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (StallCount !== 32'd8) begin bad++; $display("FAIL stall_count got=%0d exp=8", StallCount); end
`else
        total++; if (StallCount !== 32'd0) begin bad++; $display("FAIL stall_count got=%0d exp=0", StallCount); end
`endif
        InsCacheStall = 1'b0;
        step();
        total++; if (InsPC !== 32'd8 || InsOut !== 32'd108) begin bad++; $display("FAIL post_stall got=%h/%0d exp=8/108", InsPC, InsOut); end
    endtask
    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        BranchTaken = 1'b1;
        BranchTarget = 32'd32;
        DecodeReady = 1'b1;
        step();
        BranchTaken = 1'b0;
        total++; if (InsValid !== 1'b0 || ProgAddr !== 32'd32) begin bad++; $display("FAIL branch_flush got=%b/%h exp=0/20", InsValid, ProgAddr); end
        step();
        total++; if (InsValid !== 1'b1 || InsPC !== 32'd32 || InsOut !== 32'd132) begin bad++; $display("FAIL branch_target got=%b/%h/%0d exp=1/20/132", InsValid, InsPC, InsOut); end
    endtask
    task automatic test_wrap();
        do_reset();
        DecodeReady = 1'b1;
        BranchTaken = 1'b1;
        BranchTarget = 32'hFFFF_FFFF;
        step();
        BranchTaken = 1'b0;
        total++; if (ProgAddr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_load got=%h exp=ffffffff", ProgAddr); end
        step();
        total++; if (InsPC !== 32'hFFFF_FFFF || InsOut !== 32'd99 || ProgAddr !== 32'd0) begin bad++; $display("FAIL wrap_top got=%h/%0d/%h exp=ffffffff/99/0", InsPC, InsOut, ProgAddr); end
        step();
        total++; if (InsPC !== 32'd0 || InsOut !== 32'd100) begin bad++; $display("FAIL wrap_zero got=%h/%0d exp=0/100", InsPC, InsOut); end
    endtask
    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        total++; if (InsValid !== 1'b1 || ProgAddr !== 32'd4) begin bad++; $display("FAIL pre_async got=%b/%h exp=1/4", InsValid, ProgAddr); end
        #2 reset = 1'b1;
        #1;
        total++; if (InsValid !== 1'b0 || ProgAddr !== 32'd0 || InsPC !== 32'd0) begin bad++; $display("FAIL async_reset got=%b/%h/%h exp=0/0/0", InsValid, ProgAddr, InsPC); end
        @(negedge clock);
        reset = 1'b0;
    endtask
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_branch();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit_r32i.md
FETCH_UNIT_R32I -- requirements
Module: fetch_unit_r32i

Interface
REQ-001 SHALL have parameter dataW, default 32: instruction and address width.
REQ-002 SHALL have parameter QueueDepth, default 4: fetch queue entries (power of 2, >=2).
REQ-003 SHALL have parameter ResetPC, default 0: word address fetched first after reset.
REQ-004 SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port InsCacheStall  in  1  instruction cache miss/refill in progress.
REQ-007 SHALL have port OutputIns  in  dataW  cache instruction word for current ProgAddr.
REQ-008 SHALL have port ProgAddr  out  dataW  word address presented to the instruction cache.
REQ-009 SHALL have port BranchTaken  in  1  redirect request from execute.
REQ-010 SHALL have port BranchTarget  in  dataW  redirect word address.
REQ-011 SHALL have port DecodeReady  in  1  decode accepts an instruction this cycle.
REQ-012 SHALL have port InsValid  out  1  InsOut/InsPC hold a valid instruction.
REQ-013 SHALL have port InsOut  out  dataW  instruction to decode.
REQ-014 SHALL have port InsPC  out  dataW  word address of InsOut.
REQ-015 SHALL have port StallCount  out  32  cache-stall cycle counter (see Configuration).

Function
REQ-016 SHALL treat OutputIns as valid for ProgAddr in the same cycle whenever InsCacheStall=0.
REQ-017 SHALL push {ProgAddr, OutputIns} and increment ProgAddr by 1 on a clock edge when InsCacheStall=0, BranchTaken=0 and (queue not full or a pop occurs that cycle).
REQ-018 SHALL hold ProgAddr unchanged while InsCacheStall=1 or the queue is full with no pop.
REQ-019 SHALL pop the head entry on a clock edge when InsValid=1 and DecodeReady=1.
REQ-020 SHALL drive InsValid=1 iff queue not empty; InsOut/InsPC SHALL show the head entry combinationally (no extra latency).
REQ-021 SHALL, on BranchTaken=1, empty the queue and load ProgAddr<=BranchTarget at that edge, with no push; redirect has priority over push, pop and stall.
REQ-022 SHALL wrap ProgAddr from 2^dataW-1 to 0 with no error indication.
REQ-023 SHALL support simultaneous push and pop when full or empty-plus-push; occupancy changes by push-pop only.
REQ-024 SHALL preserve queue order strictly FIFO; read/write pointers wrap modulo QueueDepth.
REQ-025 SHALL deliver the first instruction one cycle after the first accepted fetch (minimum fetch-to-decode latency 1 cycle).

Reset
REQ-026 SHALL, while reset=1 and immediately on assertion (including mid-operation), set ProgAddr=ResetPC, queue empty, InsValid=0, InsOut=0, InsPC=0, StallCount=0.
REQ-027 SHALL begin fetching at the first rising clock edge after reset deasserts.

Configuration
REQ-028 SHALL, with macro FETCH_PERF_CNT_EN defined, increment StallCount on every clock edge with InsCacheStall=1, saturating at 32'hFFFFFFFF.
REQ-029 SHALL, without FETCH_PERF_CNT_EN, tie StallCount to 0 and implement no counter logic.

Structure
REQ-030 SHALL place the default dataW constant and the queue entry typedef {addr, ins} in shared package fetch_r32i_pkg.
REQ-031 SHALL implement the queue as sub-module fetch_queue_r32i (parameterised depth, push/pop/flush, full/empty).

Verification
REQ-032 Reset, InsCacheStall=0, OutputIns=ProgAddr+100, DecodeReady=1 -> InsValid from cycle 2, InsPC 0,1,2,... with InsOut 100,101,102,...
REQ-033 DecodeReady=0, no stall -> exactly 4 pushes (PC 0..3), ProgAddr held at 4; DecodeReady=1 -> drain in order 0,1,2,3 then continue at 4.
REQ-034 InsCacheStall=1 for 8 cycles at ProgAddr=8 -> ProgAddr held at 8, no pushes, StallCount=8 (macro on) / 0 (macro off).
REQ-035 BranchTaken=1, BranchTarget=32 with 3 queued entries -> next cycle InsValid=0, ProgAddr=32; following cycle InsPC=32.
REQ-036 ProgAddr=32'hFFFFFFFF fetched -> next ProgAddr=0, InsPC sequence FFFFFFFF then 0.
REQ-037 Assert reset mid-stream with full queue -> InsValid=0, ProgAddr=ResetPC asynchronously before next clock edge.
